// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared UART defaults for word width and receive FIFO depth,
// used by uart_rx, uart_tx and uart_rx_fifo.
package uart_rx_fifo_pkg;
    localparam int UART_DBITS       = 8;
    localparam int UART_FIFO_ADDR_W = 4;
endpackage

// File: rtl/fifo_regfile.sv
// fifo_regfile: FIFO storage array with a synchronous write port and an asynchronous read port.
module fifo_regfile
    import uart_rx_fifo_pkg::*;
#(
    parameter int DBITS  = UART_DBITS,
    parameter int ADDR_W = UART_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DBITS-1:0]  w_data,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DBITS-1:0]  r_data
);
    logic [DBITS-1:0] mem [2**ADDR_W];

    // Contents are deliberately not reset; the pointers alone decide validity.
    always_ff @(posedge clk) begin
        if (we) mem[w_addr] <= w_data;
    end

    assign r_data = mem[r_addr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO buffering words from the UART receiver,
// with a sticky overrun flag raised when a word arrives while full.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DBITS  = UART_DBITS,
    parameter int ADDR_W = UART_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr,
    input  logic [DBITS-1:0]  w_data,
    input  logic              rd,
    input  logic              clr_overrun,
    output logic [DBITS-1:0]  r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun
);
    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              do_wr, do_rd;

    // A pop frees a slot in the same edge, so a write at full is accepted when rd is high.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || rd);
    assign empty = count == '0;
    assign full  = count == DEPTH;

    fifo_regfile #(.DBITS(DBITS), .ADDR_W(ADDR_W)) u_regfile (
        .clk    (clk),
        .we     (do_wr),
        .w_addr (wr_ptr),
        .w_data (w_data),
        .r_addr (rd_ptr),
        .r_data (r_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            count   <= (do_wr && !do_rd) ? count + CNT_ONE :
                       (do_rd && !do_wr) ? count - CNT_ONE : count;
            overrun <= (wr && full && !rd) || (overrun && !clr_overrun);
        end
    end
endmodule
